sysbus_rr_arbiter: RTL and testbench



---
 rtl/sysbus_rr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sysbus_rr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_rr_arbiter.sv
// N-channel Sysbus request arbiter: round-robin grant, write-burst locking,
// one outstanding read per channel, and tag-matched response steering.
module sysbus_rr_arbiter #(
   parameter int NUM_CH         = 2,
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int WRITE_BEATS    = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CH-1:0]                  ch_reqcyc,
   input  logic [NUM_CH*BUS_DATA_WIDTH-1:0]   ch_req,
   input  logic [NUM_CH*BUS_TAG_WIDTH-1:0]    ch_reqtag,
   output logic [NUM_CH-1:0]                  ch_reqack,
   output logic [NUM_CH-1:0]                  ch_respcyc,
   input  logic [NUM_CH-1:0]                  ch_respack,
   output logic                               bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0]          bus_req,
   output logic [BUS_TAG_WIDTH-1:0]           bus_reqtag,
   input  logic                               bus_reqack,
   input  logic                               bus_respcyc,
   input  logic [BUS_TAG_WIDTH-1:0]           bus_resptag,
   output logic                               bus_respack,
   output logic                               resp_unmatched,
   output logic [1:0]                         dbg_state
);

   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BEAT_W = (WRITE_BEATS > 1) ? $clog2(WRITE_BEATS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [CH_W-1:0]           owner_q, owner_d;
   logic [CH_W-1:0]           last_q, last_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic [NUM_CH-1:0]         pend_vld_q, pend_vld_d;
   logic [BUS_TAG_WIDTH-1:0]  pend_tag_q [NUM_CH];
   logic [BUS_TAG_WIDTH-1:0]  pend_tag_d [NUM_CH];
   logic                      routed_q, routed_d;
   logic [CH_W-1:0]           routed_ch_q, routed_ch_d;

   logic [NUM_CH-1:0]         eligible;
   logic                      any_elig;
   logic [CH_W-1:0]           rr_pick;
   logic [NUM_CH-1:0]         match_sel;
   logic                      any_match;
   logic [CH_W-1:0]           match_idx;
   logic                      read_acc;
   logic                      own_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] own_req;
   logic [BUS_TAG_WIDTH-1:0]  own_tag;

   assign own_reqcyc = ch_reqcyc[owner_q];
   assign own_req    = ch_req[owner_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
   assign own_tag    = ch_reqtag[owner_q*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
   assign dbg_state  = state_q;

   // A read is blocked while that channel still has a read outstanding.
   always_comb begin
      eligible = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         eligible[k] = ch_reqcyc[k] &
                       ~(ch_reqtag[k*BUS_TAG_WIDTH + BUS_TAG_WIDTH - 1] & pend_vld_q[k]);
      end
   end

   always_comb begin
      any_elig = 1'b0;
      rr_pick  = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         if (!any_elig && eligible[(int'(last_q) + i) % NUM_CH]) begin
            any_elig = 1'b1;
            rr_pick  = CH_W'((int'(last_q) + i) % NUM_CH);
         end
      end
   end

   always_comb begin
      match_sel = '0;
      any_match = 1'b0;
      match_idx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!any_match && pend_vld_q[k] && (pend_tag_q[k] == bus_resptag)) begin
            any_match    = 1'b1;
            match_sel[k] = 1'b1;
            match_idx    = CH_W'(k);
         end
      end
   end

   assign ch_respcyc     = bus_respcyc ? match_sel : '0;
   assign bus_respack    = |(ch_respack & match_sel);
   assign resp_unmatched = bus_respcyc & ~any_match;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      beat_d     = beat_q;
      read_acc   = 1'b0;
      bus_reqcyc = 1'b0;
      bus_req    = '0;
      bus_reqtag = '0;
      ch_reqack  = '0;
      case (state_q)
         ST_IDLE: begin
            if (any_elig) begin
               owner_d = rr_pick;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // A requester that withdraws before the ack forfeits the grant.
            if (!own_reqcyc) begin
               state_d = ST_IDLE;
            end else begin
               bus_reqcyc         = 1'b1;
               bus_req            = own_req;
               bus_reqtag         = own_tag;
               ch_reqack[owner_q] = bus_reqack;
               if (bus_reqack) begin
                  last_d = owner_q;
                  if (own_tag[BUS_TAG_WIDTH-1]) begin
                     read_acc = 1'b1;
                     state_d  = ST_IDLE;
                  end else begin
                     beat_d  = '0;
                     state_d = ST_BURST;
                  end
               end
            end
         end
         ST_BURST: begin
            bus_reqcyc = 1'b1;
            bus_req    = own_req;
            bus_reqtag = own_tag;
            if (beat_q == BEAT_W'(WRITE_BEATS - 1)) begin
               beat_d  = '0;
               state_d = ST_IDLE;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pending read retires on the first idle bus cycle after its routed beats.
   always_comb begin
      pend_vld_d  = pend_vld_q;
      pend_tag_d  = pend_tag_q;
      routed_d    = routed_q;
      routed_ch_d = routed_ch_q;
      if (bus_respcyc && any_match) begin
         routed_d    = 1'b1;
         routed_ch_d = match_idx;
      end else if (!bus_respcyc && routed_q) begin
         routed_d                = 1'b0;
         pend_vld_d[routed_ch_q] = 1'b0;
      end
      if (read_acc) begin
         pend_vld_d[owner_q] = 1'b1;
         pend_tag_d[owner_q] = own_tag;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         last_q      <= CH_W'(NUM_CH - 1);
         beat_q      <= '0;
         pend_vld_q  <= '0;
         routed_q    <= 1'b0;
         routed_ch_q <= '0;
         for (int k = 0; k < NUM_CH; k++) pend_tag_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         beat_q      <= beat_d;
         pend_vld_q  <= pend_vld_d;
         routed_q    <= routed_d;
         routed_ch_q <= routed_ch_d;
         for (int k = 0; k < NUM_CH; k++) pend_tag_q[k] <= pend_tag_d[k];
      end
   end

endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// Bench for sysbus_rr_arbiter: directed scenarios plus random rounds, checked
// against a transaction-level model of grant order and pending reads.
module tb_sysbus_rr_arbiter;

   localparam int NUM_CH = 4;
   localparam int DW     = 64;
   localparam int TW     = 13;
   localparam int WB     = 8;

   logic                 clk;
   logic                 reset;
   logic [NUM_CH-1:0]    ch_reqcyc;
   logic [NUM_CH*DW-1:0] ch_req;
   logic [NUM_CH*TW-1:0] ch_reqtag;
   logic [NUM_CH-1:0]    ch_reqack;
   logic [NUM_CH-1:0]    ch_respcyc;
   logic [NUM_CH-1:0]    ch_respack;
   logic                 bus_reqcyc;
   logic [DW-1:0]        bus_req;
   logic [TW-1:0]        bus_reqtag;
   logic                 bus_reqack;
   logic                 bus_respcyc;
   logic [TW-1:0]        bus_resptag;
   logic                 bus_respack;
   logic                 resp_unmatched;
   logic [1:0]           dbg_state;

   sysbus_rr_arbiter #(
      .NUM_CH(NUM_CH), .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .WRITE_BEATS(WB)
   ) dut (
      .clk(clk), .reset(reset),
      .ch_reqcyc(ch_reqcyc), .ch_req(ch_req), .ch_reqtag(ch_reqtag),
      .ch_reqack(ch_reqack), .ch_respcyc(ch_respcyc), .ch_respack(ch_respack),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
      .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resptag(bus_resptag),
      .bus_respack(bus_respack), .resp_unmatched(resp_unmatched), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: requester intent and what the spec says the arbiter remembers.
   bit            r_on   [NUM_CH];
   logic [TW-1:0] r_tag  [NUM_CH];
   logic [DW-1:0] r_data [NUM_CH];
   bit            m_pend [NUM_CH];
   logic [TW-1:0] m_ptag [NUM_CH];
   int            m_last;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_reqs();
      for (int k = 0; k < NUM_CH; k++) begin
         ch_reqcyc[k]            = r_on[k];
         ch_req[k*DW +: DW]      = r_data[k];
         ch_reqtag[k*TW +: TW]   = r_tag[k];
      end
   endtask

   function automatic int model_pick();
      for (int i = 1; i <= NUM_CH; i++) begin
         int k;
         k = (m_last + i) % NUM_CH;
         if (r_on[k] && !(r_tag[k][TW-1] && m_pend[k])) return k;
      end
      return -1;
   endfunction

   // Called in the cycle the arbiter should be presenting the winner.
   task automatic serve_one();
      int w;
      int d;
      bit rd;
      logic [NUM_CH-1:0] exp_ack;
      w = model_pick();
      chk("grant_reqcyc", bus_reqcyc, 1'b1);
      chk("grant_tag", bus_reqtag, r_tag[w]);
      chk("grant_data", bus_req, r_data[w]);
      d = $urandom_range(0, 2);
      repeat (d) begin
         chk("ack_wait_zero", ch_reqack, '0);
         tick();
      end
      bus_reqack = 1'b1;
      #1;
      exp_ack = '0;
      exp_ack[w] = 1'b1;
      chk("reqack_onehot", ch_reqack, exp_ack);
      rd = r_tag[w][TW-1];
      tick();
      bus_reqack = 1'b0;
      m_last = w;
      r_on[w] = 1'b0;
      drive_reqs();
      if (rd) begin
         m_pend[w] = 1'b1;
         m_ptag[w] = r_tag[w];
      end else begin
         for (int b = 0; b < WB; b++) begin
            r_data[w] = {$urandom, $urandom};
            drive_reqs();
            #1;
            chk("burst_reqcyc", bus_reqcyc, 1'b1);
            chk("burst_data", bus_req, r_data[w]);
            chk("burst_noack", ch_reqack, '0);
            tick();
         end
      end
      #1;
      chk("idle_after_txn", bus_reqcyc, 1'b0);
   endtask

   task automatic serve_all();
      int g;
      g = 0;
      drive_reqs();
      #1;
      chk("idle_before_grant", bus_reqcyc, 1'b0);
      while (model_pick() >= 0 && g < NUM_CH + 2) begin
         tick();
         serve_one();
         g++;
      end
      tick();
      chk("no_grant_left", bus_reqcyc, 1'b0);
      chk("no_grant_state", dbg_state, 2'd0);
      for (int k = 0; k < NUM_CH; k++) r_on[k] = 1'b0;
      drive_reqs();
   endtask

   task automatic respond(input logic [TW-1:0] tag, input int beats);
      int mch;
      logic [NUM_CH-1:0] exp_cyc;
      mch = -1;
      for (int k = 0; k < NUM_CH; k++)
         if (mch < 0 && m_pend[k] && m_ptag[k] == tag) mch = k;
      exp_cyc = '0;
      if (mch >= 0) exp_cyc[mch] = 1'b1;
      for (int b = 0; b < beats; b++) begin
         bus_respcyc = 1'b1;
         bus_resptag = tag;
         ch_respack  = NUM_CH'($urandom);
         #1;
         chk("respcyc_route", ch_respcyc, exp_cyc);
         chk("respack_mirror", bus_respack, (mch >= 0) ? ch_respack[mch] : 1'b0);
         chk("resp_unmatched", resp_unmatched, (mch < 0));
         tick();
      end
      bus_respcyc = 1'b0;
      ch_respack  = '0;
      #1;
      chk("resp_end_cyc", ch_respcyc, '0);
      chk("resp_end_unm", resp_unmatched, 1'b0);
      if (mch >= 0) m_pend[mch] = 1'b0;
      tick();
   endtask

   task automatic clear_pending();
      for (int k = 0; k < NUM_CH; k++)
         if (m_pend[k]) respond(m_ptag[k], 1);
   endtask

   task automatic set_req(input int k, input logic [TW-1:0] tag);
      r_on[k]   = 1'b1;
      r_tag[k]  = tag;
      r_data[k] = {$urandom, $urandom};
   endtask

   initial begin
      reset       = 1'b1;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      bus_resptag = '0;
      ch_respack  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         r_on[k] = 1'b0; r_tag[k] = '0; r_data[k] = '0;
         m_pend[k] = 1'b0; m_ptag[k] = '0;
      end
      m_last = NUM_CH - 1;
      drive_reqs();
      #2 reset = 1'b0;
      tick();
      tick();
      chk("rst_bus_reqcyc", bus_reqcyc, 1'b0);
      chk("rst_ch_reqack", ch_reqack, '0);
      chk("rst_ch_respcyc", ch_respcyc, '0);
      chk("rst_bus_respack", bus_respack, 1'b0);
      chk("rst_unmatched", resp_unmatched, 1'b0);
      chk("rst_state", dbg_state, 2'd0);
      reset = 1'b1;
      tick();

      // Two reads: ch0 then ch1, then route responses by tag.
      set_req(0, 13'h1001);
      set_req(1, 13'h1002);
      serve_all();
      respond(13'h1002, 3);
      respond(13'h1777, 2);
      respond(13'h1001, 2);

      // Outstanding read blocks ch1's next read until its response completes.
      set_req(1, 13'h1005);
      serve_all();
      set_req(1, 13'h1015);
      set_req(2, 13'h0042);
      serve_all();
      respond(13'h1005, 8);
      set_req(1, 13'h1015);
      serve_all();
      clear_pending();

      // All channels writing.
      for (int k = 0; k < NUM_CH; k++) set_req(k, TW'(13'h0100 + k));
      serve_all();

      // Random rounds.
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            int rk;
            logic [TW-1:0] rt;
            rk = $urandom_range(0, NUM_CH - 1);
            rt = (m_pend[rk] && $urandom_range(0, 3) != 0) ? m_ptag[rk] : TW'($urandom);
            respond(rt, $urandom_range(1, 4));
         end
         for (int k = 0; k < NUM_CH; k++) begin
            r_on[k]   = ($urandom_range(0, 1) == 1);
            r_data[k] = {$urandom, $urandom};
            r_tag[k]  = ($urandom_range(0, 1) == 1) ? {1'b1, 9'($urandom), 3'(k)}
                                                    : {1'b0, 12'($urandom)};
         end
         serve_all();
      end

      // Reset during beat 3 of a write burst, with a read pending on ch0.
      clear_pending();
      set_req(0, 13'h1003);
      serve_all();
      set_req(2, 13'h0077);
      drive_reqs();
      tick();
      chk("rb_grant", bus_reqcyc, 1'b1);
      bus_reqack = 1'b1;
      tick();
      bus_reqack = 1'b0;
      r_on[2] = 1'b0;
      drive_reqs();
      repeat (3) tick();
      chk("rb_beat3_busy", bus_reqcyc, 1'b1);
      reset = 1'b0;
      #1;
      chk("rb_async_drop", bus_reqcyc, 1'b0);
      for (int k = 0; k < NUM_CH; k++) m_pend[k] = 1'b0;
      m_last = NUM_CH - 1;
      tick();
      reset = 1'b1;
      tick();
      // ch0 re-reads; it must be eligible again and win first.
      set_req(0, 13'h1003);
      set_req(1, 13'h1009);
      set_req(3, 13'h0033);
      serve_all();
      clear_pending();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
